ft232r_tx_fc: RTL and testbench

FPGA-to-FT232R UART transmit path with RTS/CTS hardware flow control. Accepts bytes from FPGA logic over a 4-phase req/ack handshake and buffers them in a small FIFO. Serializes them 8N1 onto the FT232R RXD pin, starting a new frame only while the FT232R asserts its RTS# (ready to receive). Complements the existing receive-side adapter, which handshakes incoming data only.

---
 rtl/ft232r_pkg.sv | 33 +++
 rtl/ft232r_tx_fifo.sv | 59 +++++
 rtl/ft232r_tx_fc.sv | 165 ++++++++++++++++
 tb/tb_ft232r_tx_fc.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ft232r_pkg.sv
// Shared definitions for the FT232R transmit path: baud divider helpers,
// TX FSM state encoding and frame length constants.
package ft232r_pkg;

  // Clock cycles per bit (integer truncation).
  function automatic int unsigned baud_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    return clk_hz / baud;
  endfunction

  // Width of a counter spanning 0..div-1 (at least one bit).
  function automatic int unsigned baud_cnt_w(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

  localparam int unsigned DEF_CLK_FREQ_HZ = 100000000;
  localparam int unsigned DEF_BAUD_RATE   = 3000000;
  localparam int unsigned DEF_BAUD_DIV    = baud_div(DEF_CLK_FREQ_HZ, DEF_BAUD_RATE);
  localparam int unsigned DEF_BAUD_CNT_W  = baud_cnt_w(DEF_BAUD_DIV);

  // Bit times per frame: start + 8 data + stop, optionally + parity.
  localparam int unsigned FRAME_BITS_8N1 = 10;
  localparam int unsigned FRAME_BITS_8E1 = 11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/ft232r_tx_fifo.sv
// Single-clock byte FIFO, depth 2**P_FIFO_AW, first-word fall-through read.
// Push while full and pop while empty are ignored.
module ft232r_tx_fifo #(
  parameter int unsigned P_FIFO_AW = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [7:0]         din,
  input  logic               pop,
  output logic [7:0]         dout,
  output logic [P_FIFO_AW:0] count,
  output logic               full,
  output logic               empty
);

  localparam int unsigned DEPTH = 2 ** P_FIFO_AW;
  localparam logic [P_FIFO_AW:0] DEPTH_C = {1'b1, {P_FIFO_AW{1'b0}}};

  logic [7:0]           mem [DEPTH];
  logic [P_FIFO_AW-1:0] wr_ptr;
  logic [P_FIFO_AW-1:0] rd_ptr;
  logic [P_FIFO_AW:0]   count_n;
  logic                 do_push;
  logic                 do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Next occupancy; simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_n = count;
    if (do_push && !do_pop)      count_n = count + 1'b1;
    else if (do_pop && !do_push) count_n = count - 1'b1;
  end

  // Storage write; no reset needed on the data array.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally at 2**P_FIFO_AW; full is registered with the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_n;
      full  <= (count_n == DEPTH_C);
    end
  end

endmodule

// File: rtl/ft232r_tx_fc.sv
// FPGA-to-FT232R UART transmitter with RTS#/CTS flow control.
// Bytes arrive over a 4-phase req/ack handshake, are buffered in a FIFO and
// sent 8N1 on rxd; a frame starts only while the synchronized ft_rts_n is low.
// Define FT232R_TX_PARITY_EN to insert an even parity bit (8E1).
module ft232r_tx_fc
  import ft232r_pkg::*;
#(
  parameter int unsigned P_CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
  parameter int unsigned P_BAUD_RATE   = DEF_BAUD_RATE,
  parameter int unsigned P_FIFO_AW     = 4,
  parameter int unsigned P_SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               rxd,
  input  logic               ft_rts_n,
  input  logic               rsp_req,
  input  logic [7:0]         rsp_data,
  output logic               rsp_ack,
  output logic [P_FIFO_AW:0] fifo_count,
  output logic               fifo_full,
  output logic               tx_busy
);

  localparam int unsigned BAUD_DIV = baud_div(P_CLK_FREQ_HZ, P_BAUD_RATE);
  localparam int unsigned CNT_W    = baud_cnt_w(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam int unsigned SYNC_N   = (P_SYNC_STAGES < 2) ? 2 : P_SYNC_STAGES;

  logic [SYNC_N-1:0] rts_sync;
  logic              rts_ok;
  logic              push;
  logic              pop;
  logic [7:0]        fifo_dout;
  logic              fifo_empty;
  tx_state_e         state;
  logic [CNT_W-1:0]  baud_cnt;
  logic              bit_end;
  logic [2:0]        bit_idx;
  logic [7:0]        shreg;
`ifdef FT232R_TX_PARITY_EN
  logic              par;
`endif

  // Bring asynchronous RTS# into clk; reset value 1 means "not ready".
  always_ff @(posedge clk) begin
    if (rst) rts_sync <= '1;
    else     rts_sync <= {rts_sync[SYNC_N-2:0], ft_rts_n};
  end

  assign rts_ok  = ~rts_sync[SYNC_N-1];
  assign push    = rsp_req & ~rsp_ack & ~fifo_full;
  assign pop     = (state == ST_IDLE) & ~fifo_empty & rts_ok;
  assign bit_end = (baud_cnt == CNT_LAST);

  // 4-phase acknowledge: rise on a push, hold while req high, drop after req.
  always_ff @(posedge clk) begin
    if (rst)          rsp_ack <= 1'b0;
    else if (push)    rsp_ack <= 1'b1;
    else if (!rsp_req) rsp_ack <= 1'b0;
  end

  ft232r_tx_fifo #(
    .P_FIFO_AW (P_FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (rsp_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Frame serializer; rxd is registered and leads the state by zero cycles,
  // so each state's line level is loaded on the transition into it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      rxd      <= 1'b1;
      tx_busy  <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
`ifdef FT232R_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          rxd <= 1'b1;
          if (pop) begin
            shreg    <= fifo_dout;
`ifdef FT232R_TX_PARITY_EN
            par      <= ^fifo_dout;
`endif
            rxd      <= 1'b0;
            tx_busy  <= 1'b1;
            baud_cnt <= '0;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            rxd      <= shreg[0];
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef FT232R_TX_PARITY_EN
              rxd   <= par;
              state <= ST_PARITY;
`else
              rxd   <= 1'b1;
              state <= ST_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              rxd     <= shreg[1];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`ifdef FT232R_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_end) begin
            baud_cnt <= '0;
            rxd      <= 1'b1;
            state    <= ST_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            rxd      <= 1'b1;
            tx_busy  <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          rxd     <= 1'b1;
          tx_busy <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ft232r_tx_fc.sv
// Self-checking bench for ft232r_tx_fc: directed scenarios plus a random
// burst, with every captured line frame compared against a waveform built
// from the UART framing rules.
module tb_ft232r_tx_fc;

  localparam int DIV = 100000000 / 3000000;
`ifdef FT232R_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FW   = NB * DIV;
  localparam int WMAX = 11 * DIV + 1;

  typedef struct {
    int              t0;
    logic [WMAX-1:0] wave;
    logic [WMAX-1:0] busy;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       ft_rts_n;
  logic       rsp_req;
  logic [7:0] rsp_data;
  logic       rsp_ack;
  logic [4:0] fifo_count;
  logic       fifo_full;
  logic       tx_busy;

  int     cyc = 0;
  int     n_total = 0;
  int     n_pass = 0;
  frame_t frames[$];

  // Monitor state
  frame_t cur;
  logic   cap = 1'b0;
  logic   prev_rxd = 1'b1;
  int     idx = 0;

  ft232r_tx_fc #(
    .P_CLK_FREQ_HZ (100000000),
    .P_BAUD_RATE   (3000000),
    .P_FIFO_AW     (4),
    .P_SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .ft_rts_n   (ft_rts_n),
    .rsp_req    (rsp_req),
    .rsp_data   (rsp_data),
    .rsp_ack    (rsp_ack),
    .fifo_count (fifo_count),
    .fifo_full  (fifo_full),
    .tx_busy    (tx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Capture each frame from the start-bit fall through the following cycle.
  always @(negedge clk) begin
    if (rst) begin
      cap      = 1'b0;
      prev_rxd = 1'b1;
    end else if (cap) begin
      cur.wave[idx] = rxd;
      cur.busy[idx] = tx_busy;
      idx++;
      if (idx > FW) begin
        frames.push_back(cur);
        cap = 1'b0;
      end
      prev_rxd = rxd;
    end else begin
      if (prev_rxd && !rxd) begin
        cap      = 1'b1;
        cur.t0   = cyc;
        cur.wave = '0;
        cur.busy = '0;
        cur.wave[0] = rxd;
        cur.busy[0] = tx_busy;
        idx = 1;
      end
      prev_rxd = rxd;
    end
  end

  // Expected line: start 0, data LSB first, [even parity], stop 1, then idle 1.
  function automatic logic [WMAX-1:0] exp_wave(input logic [7:0] d);
    logic [WMAX-1:0] w;
    int b;
    w = '0;
    for (int i = 0; i <= FW; i++) begin
      b = i / DIV;
      if (b == 0)                w[i] = 1'b0;
      else if (b <= 8)           w[i] = d[b-1];
      else if (NB == 11 && b == 9) w[i] = ^d;
      else                       w[i] = 1'b1;
    end
    return w;
  endfunction

  function automatic logic [WMAX-1:0] exp_busy();
    logic [WMAX-1:0] w;
    w = '0;
    for (int i = 0; i < FW; i++) w[i] = 1'b1;
    return w;
  endfunction

  function automatic int t0_of(input int k);
    if (k < frames.size()) return frames[k].t0;
    return -100000;
  endfunction

  task automatic check(input string tag, input logic [WMAX-1:0] got,
                       input logic [WMAX-1:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b, output int ack_c);
    int k;
    rsp_data = b;
    rsp_req  = 1'b1;
    k = 0;
    do begin
      tick(1);
      k++;
    end while (!rsp_ack && k < 5000);
    ack_c = cyc;
    check("ack_rise", rsp_ack, 1);
    rsp_req = 1'b0;
    tick(1);
    check("ack_drop", rsp_ack, 0);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k;
    k = 0;
    while (frames.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    check("frame_count", frames.size(), n);
  endtask

  task automatic check_frame(input int k, input logic [7:0] d, input string tag);
    if (k >= frames.size()) begin
      check({tag, "_missing"}, frames.size(), k + 1);
    end else begin
      check({tag, "_wave"}, frames[k].wave, exp_wave(d));
      check({tag, "_busy"}, frames[k].busy, exp_busy());
    end
  endtask

  initial begin
    int         nf;
    int         ack_c;
    int         l;
    int         gaps_ok;
    logic [7:0] b;
    logic [7:0] expq[$];

    rst = 1'b1; ft_rts_n = 1'b1; rsp_req = 1'b0; rsp_data = '0;
    tick(3);
    rst = 1'b0;
    check("rst_rxd", rxd, 1);
    check("rst_ack", rsp_ack, 0);
    check("rst_count", fifo_count, 0);
    check("rst_full", fifo_full, 0);
    check("rst_busy", tx_busy, 0);

    // 1: single byte, latency and handshake
    ft_rts_n = 1'b0;
    tick(5);
    nf = frames.size();
    write_byte(8'hA5, ack_c);
    wait_frames(nf + 1, 500);
    check_frame(nf, 8'hA5, "t1_a5");
    check("t1_latency", t0_of(nf) - ack_c, 1);
    check("t1_idle_busy", tx_busy, 0);

    // 2: held by RTS#, then three back-to-back frames
    ft_rts_n = 1'b1;
    tick(4);
    nf = frames.size();
    write_byte(8'h11, ack_c);
    write_byte(8'h22, ack_c);
    write_byte(8'h33, ack_c);
    tick(5);
    check("t2_hold_count", fifo_count, 3);
    check("t2_hold_rxd", rxd, 1);
    check("t2_hold_frames", frames.size(), nf);
    ft_rts_n = 1'b0;
    l = cyc;
    wait_frames(nf + 3, 1200);
    // Two sync edges make rts_ok true; the third edge pops and drops rxd.
    check("t2_rts_latency", t0_of(nf) - l, 3);
    check_frame(nf,     8'h11, "t2_11");
    check_frame(nf + 1, 8'h22, "t2_22");
    check_frame(nf + 2, 8'h33, "t2_33");
    check("t2_gap1", t0_of(nf + 1) - t0_of(nf), FW + 1);
    check("t2_total", t0_of(nf + 2) + FW - t0_of(nf), 3 * FW + 2);

    // 3: fill the FIFO, 17th request waits for space
    ft_rts_n = 1'b1;
    tick(4);
    nf = frames.size();
    expq.delete();
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      expq.push_back(b);
      write_byte(b, ack_c);
    end
    check("t3_full", fifo_full, 1);
    check("t3_count16", fifo_count, 16);
    b = 8'($urandom);
    expq.push_back(b);
    rsp_data = b;
    rsp_req  = 1'b1;
    tick(5);
    check("t3_no_ack_full", rsp_ack, 0);
    check("t3_count_held", fifo_count, 16);
    ft_rts_n = 1'b0;
    l = 0;
    while (!rsp_ack && l < 2000) begin
      tick(1);
      l++;
    end
    ack_c = cyc;
    check("t3_ack17", rsp_ack, 1);
    rsp_req = 1'b0;
    tick(1);
    wait_frames(nf + 17, 17 * 400);
    check("t3_ack_after_pop", ack_c - t0_of(nf), 1);
    gaps_ok = 1;
    for (int i = 0; i < 17; i++) begin
      check_frame(nf + i, expq[i], $sformatf("t3_b%0d", i));
      if (i > 0 && t0_of(nf + i) - t0_of(nf + i - 1) != FW + 1) gaps_ok = 0;
    end
    check("t3_gaps", gaps_ok, 1);

    // 4: RTS# deasserted mid-frame; current frame completes, next is held
    tick(4);
    nf = frames.size();
    write_byte(8'h3C, ack_c);
    tick(45);
    check("t4_in_frame", tx_busy, 1);
    ft_rts_n = 1'b1;
    write_byte(8'h55, ack_c);
    wait_frames(nf + 1, 500);
    tick(30);
    check("t4_held_count", fifo_count, 1);
    check("t4_held_frames", frames.size(), nf + 1);
    check("t4_held_rxd", rxd, 1);
    check_frame(nf, 8'h3C, "t4_3c");
    ft_rts_n = 1'b0;
    wait_frames(nf + 2, 500);
    check_frame(nf + 1, 8'h55, "t4_55");

    // 5: reset mid-frame truncates and empties the FIFO
    tick(4);
    nf = frames.size();
    write_byte(8'h96, ack_c);
    write_byte(8'hE1, ack_c);
    tick(100);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t5_rxd", rxd, 1);
    check("t5_count", fifo_count, 0);
    check("t5_ack", rsp_ack, 0);
    check("t5_busy", tx_busy, 0);
    tick(10);
    check("t5_no_frames", frames.size(), nf);
    write_byte(8'h5A, ack_c);
    wait_frames(nf + 1, 500);
    check_frame(nf, 8'h5A, "t5_5a");

`ifdef FT232R_TX_PARITY_EN
    // 6: even parity bit
    tick(4);
    nf = frames.size();
    write_byte(8'h07, ack_c);
    wait_frames(nf + 1, 500);
    check_frame(nf, 8'h07, "t6_07");
    if (nf < frames.size()) check("t6_parity", frames[nf].wave[9 * DIV + DIV / 2], 1);
`endif

    // 7: random bytes with RTS# toggling independently
    tick(4);
    nf = frames.size();
    expq.delete();
    fork
      begin
        int ac;
        logic [7:0] rb;
        for (int i = 0; i < 12; i++) begin
          rb = 8'($urandom);
          expq.push_back(rb);
          write_byte(rb, ac);
          tick($urandom_range(0, 40));
        end
      end
      begin
        for (int i = 0; i < 6; i++) begin
          ft_rts_n = 1'($urandom_range(0, 1));
          tick($urandom_range(20, 500));
        end
        ft_rts_n = 1'b0;
      end
    join
    wait_frames(nf + 12, 12 * 400);
    for (int i = 0; i < 12; i++) check_frame(nf + i, expq[i], $sformatf("t7_b%0d", i));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
